// File: rtl/floor_call_panel.sv
`default_nettype none
// ============================================================================
// floor_call_panel - debounces floor-call buttons, latches calls and lamps,
// and issues calls round-robin as single-cycle requests to the controller.
// Optional macro CALL_RESEND_EN re-arms issued calls left unserved too long.
// Revision: 1.0
// ============================================================================
module floor_call_panel #(
    parameter int NUM_FLOORS    = 8,
    parameter int DEB_CYCLES    = 4,
    parameter int REQ_GAP       = 2,
    parameter int RESEND_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] buttons,
    input  logic                  door,
    input  logic [2:0]            current_floor,
    input  logic                  emergency_stop,
    output logic [2:0]            req_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] call_lamps,
    output logic [3:0]            pending_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GAP   = 1'b1;
    localparam logic [7:0] DEB_MAX  = 8'(DEB_CYCLES);
    localparam logic [3:0] GAP_LOAD = 4'(REQ_GAP);

    if (NUM_FLOORS != 8 || DEB_CYCLES < 1 || DEB_CYCLES > 255 ||
        REQ_GAP < 0 || REQ_GAP > 15 ||
        RESEND_CYCLES < 1 || RESEND_CYCLES > 65535) begin : g_param_check
        $error("floor_call_panel: parameter out of range");
    end

    logic [NUM_FLOORS-1:0] sync1;
    logic [NUM_FLOORS-1:0] sync2;
    logic [NUM_FLOORS-1:0] press;
    logic [7:0]            deb_cnt [NUM_FLOORS];

    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] issued;
    logic [NUM_FLOORS-1:0] pend_n;
    logic [NUM_FLOORS-1:0] iss_n;
    logic [NUM_FLOORS-1:0] service_mask;
    logic [NUM_FLOORS-1:0] avail;

    logic [2:0]            search_start;
    logic [2:0]            sel;
    logic                  sel_found;
    logic                  issue_ok;
    logic                  issue;
    logic                  resend;

    logic [3:0]            gap_cnt;
    logic [0:0]            state;
    logic [0:0]            state_next;

    function automatic logic [3:0] popcount(input logic [NUM_FLOORS-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

    // Two-flop synchronizer feeding a saturating run-length debouncer.
    // press fires on the edge where the counter lands on DEB_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            press <= '0;
            for (int f = 0; f < NUM_FLOORS; f++) begin
                deb_cnt[f] <= '0;
            end
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            for (int f = 0; f < NUM_FLOORS; f++) begin
                press[f] <= sync2[f] && (deb_cnt[f] == DEB_MAX - 8'd1);
                if (!sync2[f]) begin
                    deb_cnt[f] <= '0;
                end else if (deb_cnt[f] != DEB_MAX) begin
                    deb_cnt[f] <= deb_cnt[f] + 8'd1;
                end
            end
        end
    end

    assign service_mask = door ? (NUM_FLOORS'(1) << current_floor) : '0;
    // A call being served this cycle is never handed out.
    assign avail        = pending & ~service_mask;

    always_comb begin
        logic [2:0] idx;
        sel       = search_start;
        sel_found = 1'b0;
        idx       = search_start;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            idx = search_start + 3'(k);
            if (!sel_found && avail[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    assign issue_ok = sel_found && !emergency_stop;

`ifdef CALL_RESEND_EN
    localparam logic [15:0] RESEND_LAST = 16'(RESEND_CYCLES - 1);
    logic [15:0] resend_timer;

    assign resend = (issued != '0) && !door && (resend_timer == RESEND_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resend_timer <= '0;
        end else if ((issued == '0) || door || resend) begin
            resend_timer <= '0;
        end else begin
            resend_timer <= resend_timer + 16'd1;
        end
    end
`else
    assign resend = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state; GAP ends on the edge where gap_cnt reaches zero
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (issue_ok) state_next = ST_GAP;
            ST_GAP:  if (gap_cnt <= 4'd1) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        issue = (state == ST_IDLE) && issue_ok;
    end

    // Ordering matters: resend, then issue, then new presses, and service last
    // so that a service always wins over any other update to the same floor.
    always_comb begin
        pend_n = pending;
        iss_n  = issued;
        if (resend) begin
            pend_n = pend_n | iss_n;
            iss_n  = '0;
        end
        if (issue) begin
            pend_n[sel] = 1'b0;
            iss_n[sel]  = 1'b1;
        end
        pend_n = pend_n | (press & ~call_lamps);
        pend_n = pend_n & ~service_mask;
        iss_n  = iss_n & ~service_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending       <= '0;
            issued        <= '0;
            call_lamps    <= '0;
            pending_count <= '0;
            search_start  <= '0;
            req_valid     <= 1'b0;
            req_floor     <= '0;
            gap_cnt       <= '0;
        end else begin
            pending       <= pend_n;
            issued        <= iss_n;
            call_lamps    <= pend_n | iss_n;
            pending_count <= popcount(pend_n | iss_n);
            req_valid     <= issue;
            if (issue) begin
                req_floor    <= sel;
                search_start <= sel + 3'd1;
                gap_cnt      <= GAP_LOAD;
            end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_floor_call_panel.sv
`default_nettype none
// Bench for floor_call_panel: vector table, directed corner sequences and a
// random run, all compared against a behavioural model of the call panel.
module tb_floor_call_panel;

    localparam int DEB     = 4;
    localparam int GAP     = 2;
    localparam int RESEND  = 10;
    localparam int SPACING = ((GAP < 1) ? 1 : GAP) + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] buttons;
    logic       door;
    logic [2:0] current_floor;
    logic       emergency_stop;
    logic [2:0] req_floor;
    logic       req_valid;
    logic [7:0] call_lamps;
    logic [3:0] pending_count;

    always #5 clk = ~clk;

    floor_call_panel #(
        .NUM_FLOORS(8), .DEB_CYCLES(DEB), .REQ_GAP(GAP), .RESEND_CYCLES(RESEND)
    ) dut (
        .clk(clk), .reset(reset), .buttons(buttons), .door(door),
        .current_floor(current_floor), .emergency_stop(emergency_stop),
        .req_floor(req_floor), .req_valid(req_valid),
        .call_lamps(call_lamps), .pending_count(pending_count)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int npulse = 0;
    int last_pulse_floor = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural model: calls as bit sets, debounce as run lengths, and
    // issue pacing as "cycles since the last request".
    logic [7:0] m_s1, m_s2, m_press, m_pend, m_iss;
    int         m_run [8];
    int         m_last, m_since, m_timer, m_floor;
    bit         m_valid;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_press = 0; m_pend = 0; m_iss = 0;
        for (int f = 0; f < 8; f++) m_run[f] = 0;
        m_last = 7; m_since = 1000; m_timer = 0; m_floor = 0; m_valid = 0;
    endtask

    task automatic model_step();
        logic [7:0] p, i, avail, lamps_old, press_new;
        int sel;
        bit iss_now;
        lamps_old = m_pend | m_iss;
        avail = m_pend;
        if (door) avail[current_floor] = 1'b0;
        iss_now = 0;
        sel = 0;
        if (m_since >= SPACING && !emergency_stop)
            for (int k = 1; k <= 8; k++)
                if (!iss_now && avail[(m_last + k) % 8]) begin
                    iss_now = 1;
                    sel = (m_last + k) % 8;
                end
        p = m_pend;
        i = m_iss;
`ifdef CALL_RESEND_EN
        if (i == 0 || door) m_timer = 0;
        else if (m_timer + 1 == RESEND) begin p = p | i; i = 0; m_timer = 0; end
        else m_timer++;
`endif
        if (iss_now) begin p[sel] = 1'b0; i[sel] = 1'b1; m_last = sel; end
        for (int f = 0; f < 8; f++)
            if (m_press[f] && !lamps_old[f]) p[f] = 1'b1;
        if (door) begin p[current_floor] = 1'b0; i[current_floor] = 1'b0; end
        for (int f = 0; f < 8; f++) begin
            m_run[f] = m_s2[f] ? ((m_run[f] < 1000) ? m_run[f] + 1 : 1000) : 0;
            press_new[f] = (m_run[f] == DEB);
        end
        m_press = press_new;
        m_s2 = m_s1;
        m_s1 = buttons;
        m_pend = p;
        m_iss = i;
        m_valid = iss_now;
        if (iss_now) m_floor = sel;
        m_since = iss_now ? 1 : ((m_since < 1000) ? m_since + 1 : m_since);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("req_valid", req_valid, m_valid);
        if (m_valid) check("req_floor", req_floor, m_floor);
        check("call_lamps", call_lamps, m_pend | m_iss);
        check("pending_count", pending_count, $countones(m_pend | m_iss));
        if (req_valid) begin npulse++; last_pulse_floor = req_floor; end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic serve(input int f);
        door = 1'b1; current_floor = 3'(f);
        step();
        door = 1'b0;
    endtask

    task automatic wait_pulse(input int bound, input string name, output int floor);
        int n0;
        n0 = npulse;
        for (int k = 0; k < bound && npulse == n0; k++) step();
        check({name, "_seen"}, int'(npulse != n0), 1);
        floor = (npulse != n0) ? last_pulse_floor : -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] btn;
        logic       dr;
        logic [2:0] cur;
        logic       valid;
        logic [2:0] floor;
        logic [7:0] lamps;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [12];
    int   n0, fl, got, first_cyc, second_cyc;
    int   rr_f [4];
    int   rr_c [4];

    initial begin
        // Single call on floor 5, held; served at row 9.
        for (int n = 0; n < 6; n++) tbl[n] = '{8'h20, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 4'd0};
        tbl[6]  = '{8'h20, 1'b0, 3'd0, 1'b0, 3'd0, 8'h20, 4'd1};
        tbl[7]  = '{8'h20, 1'b0, 3'd0, 1'b1, 3'd5, 8'h20, 4'd1};
        tbl[8]  = '{8'h20, 1'b0, 3'd0, 1'b0, 3'd0, 8'h20, 4'd1};
        tbl[9]  = '{8'h20, 1'b1, 3'd5, 1'b0, 3'd0, 8'h00, 4'd0};
        tbl[10] = '{8'h20, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 4'd0};
        tbl[11] = '{8'h20, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 4'd0};

        buttons = 0; door = 0; current_floor = 0; emergency_stop = 0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", req_valid, 0);
        check("reset_floor", req_floor, 0);
        check("reset_lamps", call_lamps, 0);
        check("reset_count", pending_count, 0);
        reset = 1'b0;

        for (int n = 0; n < 12; n++) begin
            buttons = tbl[n].btn; door = tbl[n].dr; current_floor = tbl[n].cur;
            step();
            check("tbl_valid", req_valid, tbl[n].valid);
            if (tbl[n].valid) check("tbl_floor", req_floor, tbl[n].floor);
            check("tbl_lamps", call_lamps, tbl[n].lamps);
            check("tbl_count", pending_count, tbl[n].cnt);
        end
        buttons = 0; door = 0;
        run(4);

        // Reset in the middle of a burst of calls and requests.
        buttons = 8'h0F;
        run(10);
        buttons = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("midrst_valid", req_valid, 0);
        check("midrst_lamps", call_lamps, 0);
        check("midrst_count", pending_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        n0 = npulse;
        run(30);
        check("post_reset_pulses", npulse - n0, 0);

        // Glitch shorter than the debounce window, then a long hold.
        n0 = npulse;
        buttons = 8'h04; run(3);
        buttons = 8'h00; run(15);
        check("glitch_lamps", call_lamps, 0);
        check("glitch_pulses", npulse - n0, 0);
        buttons = 8'h04; run(100);
        check("hold_pulses", npulse - n0, 1);
        check("hold_lamps", call_lamps, 8'h04);
        buttons = 0;
        serve(2);
        run(2);
        check("hold_served", call_lamps, 0);

        // Round robin from reset order, with floor 0 joining after the first request.
        do_reset();
        for (int k = 0; k < 4; k++) begin rr_f[k] = -1; rr_c[k] = -100; end
        got = 0;
        buttons = 8'h52;
        for (int k = 0; k < 60 && got < 4; k++) begin
            step();
            if (req_valid) begin
                rr_f[got] = req_floor; rr_c[got] = cyc; got++;
                buttons = 8'h53;
            end
        end
        check("rr_count", got, 4);
        check("rr_first", rr_f[0], 1);
        check("rr_second", rr_f[1], 4);
        check("rr_third", rr_f[2], 6);
        check("rr_fourth", rr_f[3], 0);
        check("rr_gap_a", rr_c[1] - rr_c[0], 3);
        check("rr_gap_b", rr_c[2] - rr_c[1], 3);
        check("rr_gap_c", int'(rr_c[3] - rr_c[2] >= 3), 1);
        buttons = 0;
        serve(0); serve(1); serve(4); serve(6);
        run(2);
        check("rr_cleared", call_lamps, 0);

        // Emergency stop holds a pending call; release lets it out.
        n0 = npulse;
        emergency_stop = 1'b1;
        buttons = 8'h08;
        run(20);
        check("estop_lamp", call_lamps, 8'h08);
        check("estop_pulses", npulse - n0, 0);
        buttons = 0;
        emergency_stop = 1'b0;
        wait_pulse(5, "estop_release", fl);
        check("estop_floor", fl, 3);
        serve(3);

        // Press on the floor where the door is already open.
        n0 = npulse;
        door = 1'b1; current_floor = 3'd2;
        buttons = 8'h04;
        run(15);
        check("served_press_lamps", call_lamps, 0);
        check("served_press_pulses", npulse - n0, 0);
        buttons = 0; door = 0;
        run(3);
        check("served_press_after", call_lamps, 0);

        // Issued call left unserved with the door shut.
        buttons = 8'h80;
        wait_pulse(20, "resend_first", fl);
        check("resend_first_floor", fl, 7);
        buttons = 0;
        first_cyc = cyc;
        second_cyc = -1;
        n0 = npulse;
        for (int k = 0; k < 200; k++) begin
            step();
            if (req_valid && second_cyc < 0) second_cyc = cyc;
        end
`ifdef CALL_RESEND_EN
        check("resend_delay", second_cyc - first_cyc, 11);
        check("resend_floor_again", int'(npulse > n0), 1);
`else
        check("no_resend", npulse - n0, 0);
        check("no_resend_lamp", call_lamps, 8'h80);
`endif
        serve(7);
        run(3);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            for (int f = 0; f < 8; f++)
                if ($urandom_range(0, 15) == 0) buttons[f] = ~buttons[f];
            door = ($urandom_range(0, 7) == 0);
            current_floor = 3'($urandom_range(0, 7));
            emergency_stop = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
